// File: rtl/spi_slave_rx.sv
// spi_slave_rx: oversampled SPI receive stage (mode 0, MSB first, 8-bit frames).
// sck/mosi/ss are synchronized into clk; a byte is shifted in on sck rising
// edges and handed to the consumer through a valid/ack holding register.
// Optional build macro: SPI_RX_TIMEOUT_EN aborts a frame when sck stalls in SHIFT.
module spi_slave_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       mosi,
  input  logic       ss,
  input  logic       ack,
  output logic [7:0] dataRX,
  output logic       valid,
  output logic       overrun,
  output logic       frameErr,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_END} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, ss_sync_q, warm_q;
  logic                   sck_dly_q;
  logic                   arm_q;
  logic [7:0]             shift_q, shift_d;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;
  logic                   ferr_q, ferr_d;
  logic                   sck_s, mosi_s, ss_s, sck_rise;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_dly_q;

  // Synchronizers; mosi has the same depth as sck so the sampled bit lines up with sck_rise.
  // warm_q fills with ones once the synchronizers hold real post-reset samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '0;
      warm_q      <= '0;
      sck_dly_q   <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
      warm_q      <= {warm_q[SYNC_STAGES-2:0], 1'b1};
      sck_dly_q   <= sck_s;
    end
  end

  // Arm frame entry only after ss has genuinely been seen low since reset, so a
  // frame already in flight when reset hits is not picked up half way through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) arm_q <= 1'b0;
    else     arm_q <= arm_q | (warm_q[SYNC_STAGES-1] & ~ss_s);
  end

`ifdef SPI_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout;

  // Idle-sck counter: runs in SHIFT, cleared by every sck rise and outside SHIFT.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == SHIFT && !sck_rise) to_cnt_d = to_cnt_q + TW'(1);
  end
  assign timeout = (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) && !sck_rise;

  // Timeout counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`endif

  // Next-state, shifter and holding-register logic.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    data_d    = data_q;
    valid_d   = valid_q & ~ack;
    overrun_d = overrun_q;
    ferr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_s && arm_q) begin
          state_d  = SHIFT;
          shift_d  = '0;
          bitcnt_d = '0;
        end
      end
      SHIFT: begin
        if (!ss_s) begin
          state_d = IDLE;
          ferr_d  = (bitcnt_q != 3'd0);
        end else if (sck_rise) begin
          shift_d  = {shift_q[6:0], mosi_s};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            // An ack on this cycle consumes the old byte, so no overrun then.
            data_d    = {shift_q[6:0], mosi_s};
            valid_d   = 1'b1;
            overrun_d = overrun_q | (valid_q & ~ack);
            state_d   = WAIT_END;
          end
`ifdef SPI_RX_TIMEOUT_EN
        end else if (timeout) begin
          ferr_d  = 1'b1;
          shift_d = '0;
          state_d = WAIT_END;
`endif
        end
      end
      WAIT_END: begin
        if (!ss_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bitcnt_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
    end
  end

  assign dataRX   = data_q;
  assign valid    = valid_q;
  assign overrun  = overrun_q;
  assign frameErr = ferr_q;
  assign busy     = (state_q == SHIFT);

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- SPI receive stage that sits directly downstream of the team's SPI byte transmitter.
- Oversamples sck/mosi/ss in the system clock domain and shifts in one byte per frame, MSB first, on sck rising edges.
- Presents the byte to the consumer through a valid/ack holding register.
- Flags overrun, aborted frames and, optionally, stalled frames.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on sck, mosi and ss (legal values 2..3).
- TIMEOUT_CYCLES, 255, clk cycles without a sck rising edge while ss is high before the frame is aborted (used only with SPI_RX_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous, active-high reset.
- sck  input  1  SPI clock from the master; idles low; asynchronous to clk.
- mosi  input  1  SPI serial data; must be stable around the sck rising edge.
- ss  input  1  slave select, active-high; frame lasts while ss is high.
- ack  input  1  consumer acknowledge; clears valid.
- dataRX  output  8  last completed byte.
- valid  output  1  dataRX holds an unacknowledged byte.
- overrun  output  1  sticky; a byte completed while valid was high.
- frameErr  output  1  one-cycle pulse; frame aborted before 8 bits.
- busy  output  1  high in SHIFT state.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0; shift register 0; bit counter 0; all synchronizer flops 0; state IDLE.
- Synchronization:
  - sck, mosi and ss each pass through SYNC_STAGES flops.
  - One extra flop on synced sck gives sckRise = synced & ~delayed.
  - mosi uses the same depth, so the sampled bit is time-aligned with sckRise.
- Input timing: sck high and sck low must each be ≥ SYNC_STAGES clk cycles. Shorter pulses are not guaranteed to be seen.
- FSM states: IDLE, SHIFT, WAIT_END.
  - IDLE: synced ss high → SHIFT, bitCnt = 0, shift register cleared.
  - SHIFT:
    - Each sckRise: shift <= {shift[6:0], mosiSync}; bitCnt++.
    - On the sckRise with bitCnt == 7: dataRX <= {shift[6:0], mosiSync}; valid <= 1; state → WAIT_END.
    - Synced ss low with bitCnt ≠ 0: frameErr pulses 1 cycle; → IDLE; dataRX and valid unchanged.
    - Synced ss low with bitCnt == 0: → IDLE, no error.
  - WAIT_END: further sckRise events are ignored. Synced ss low → IDLE.
- Latency: valid rises on the (SYNC_STAGES+1)-th clk rising edge, counting the edge that first captures the 8th sck rising edge. That is 3 edges for SYNC_STAGES = 2.
- Handshake:
  - valid stays high until sampled with ack = 1; it drops on the next clk edge.
  - ack while valid = 0 has no effect.
- Simultaneous byte completion and ack on the same cycle:
  - The new byte loads and valid stays 1.
  - overrun is not set, because the old byte was consumed.
- Overrun:
  - A byte completes while valid = 1 and ack = 0 → overrun <= 1.
  - dataRX is overwritten with the new byte.
  - overrun clears only on rst.
- Reset mid-frame: everything returns to reset values immediately. A partial frame still in progress after reset is seen as a new frame only after synced ss has been observed low then high.
  - Rule: entry to SHIFT requires a low→high transition of synced ss.
- busy: 1 exactly while state == SHIFT.

Optional Feature:
- Macro: SPI_RX_TIMEOUT_EN.
- Defined:
  - A timeout counter runs in SHIFT. It resets on every sckRise and on entry to SHIFT.
  - Reaching TIMEOUT_CYCLES gives: frameErr pulse, → WAIT_END, shift register cleared, no byte delivered.
- Undefined: the counter logic is absent and SHIFT waits indefinitely for sck or for ss low.

Test Plan:
- Single byte: ss high, send 0xA5 MSB first with sck high/low 3 clk each, then ack 2 cycles after valid → dataRX = 0xA5; valid high from 3 edges after the 8th sck rise until 1 cycle after ack; overrun = 0; frameErr never pulses.
- Back-to-back without ack: frames 0x3C then 0xC3, ack never asserted → dataRX = 0xC3, valid = 1, overrun = 1.
- Ack coincident with completion: frame 0x11 completes; ack asserted on the exact cycle frame 0x22 completes → dataRX = 0x22, valid = 1, overrun = 0.
- Aborted frame: ss drops after 5 sck rises → frameErr pulses for exactly 1 cycle; valid stays 0; busy falls; a following 0x7E frame is received correctly.
- Extra clocks and reset: 10 sck rises in one ss window with data 0xF0 followed by 2 extra bits → dataRX = 0xF0 with extra bits ignored; rst asserted mid-frame with ss held high → all outputs 0 and no byte delivered until ss toggles low then high.
- Timeout (SPI_RX_TIMEOUT_EN, TIMEOUT_CYCLES = 20): 3 sck rises, then sck idle for 25 cycles with ss high → frameErr pulse at cycle 20 after the last edge; state WAIT_END; valid = 0.
